// File: rtl/sdram_pkg.sv
// Shared constants and types for the SDRAM refresh timer slice.
package sdram_pkg;

    localparam int DEFAULT_INTERVAL_CYCLES = 780;
    localparam int PENDING_W               = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } refresh_state_e;

endpackage

// File: rtl/down_counter.sv
// Reloadable down-counter: counts RELOAD..0, then reloads instead of wrapping.
module down_counter #(
    parameter int               WIDTH  = 10,
    parameter logic [WIDTH-1:0] RELOAD = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        // NOTE: default first so every path assigns count_d; otherwise a latch is inferred.
        count_d = count_q;
        if (load) begin
            count_d = RELOAD;
        end else if (en) begin
            count_d = (count_q == '0) ? RELOAD : count_q - WIDTH'(1);
        end
    end

    // NOTE: non-blocking assignment for flops so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/sdram_refresh_timer.sv
// Generates periodic refresh ticks and tracks outstanding refresh requests
// against controller acknowledgements, flagging ticks lost at saturation.
module sdram_refresh_timer
    import sdram_pkg::*;
#(
    parameter int interval_cycles  = DEFAULT_INTERVAL_CYCLES,
    parameter int max_pending      = 8,
    parameter int urgent_threshold = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 refresh_ack,
    output logic                 refresh_req,
    output logic                 refresh_urgent,
    output logic [PENDING_W-1:0] pending,
    output logic                 overflow
);

    localparam int                   CNT_W     = $clog2(interval_cycles);
    localparam logic [CNT_W-1:0]     RELOAD    = CNT_W'(interval_cycles - 1);
    localparam logic [PENDING_W-1:0] MAX_PEND  = PENDING_W'(max_pending);
    localparam logic [PENDING_W-1:0] URGENT_TH = PENDING_W'(urgent_threshold);

    refresh_state_e       state_q, state_d;
    logic [PENDING_W-1:0] pending_q, pending_d;
    logic                 overflow_q, overflow_d;
    logic                 refresh_req_q, refresh_req_d;
    logic                 refresh_urgent_q, refresh_urgent_d;

    logic [CNT_W-1:0]     cnt_count;
    logic                 cnt_zero;
    logic                 cnt_load;
    logic                 cnt_en;
    logic                 tick;

    // Held at the reload value whenever refresh is suspended, so every entry
    // into RUN starts a full interval.
    assign cnt_load = (state_q == IDLE) || !enable;
    assign cnt_en   = (state_q == RUN);
    assign tick     = (state_q == RUN) && cnt_zero;

    down_counter #(
        .WIDTH  (CNT_W),
        .RELOAD (RELOAD)
    ) u_interval_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .en    (cnt_en),
        .count (cnt_count),
        .zero  (cnt_zero)
    );

    always_comb begin
        state_d    = enable ? RUN : IDLE;
        pending_d  = pending_q;
        overflow_d = overflow_q;

        if ((state_q == IDLE) || !enable) begin
            pending_d = '0;
        end else if (tick && !refresh_ack) begin
            if (pending_q == MAX_PEND) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + PENDING_W'(1);
            end
        end else if (refresh_ack && !tick && (pending_q != '0)) begin
            pending_d = pending_q - PENDING_W'(1);
        end

        refresh_req_d    = (pending_d != '0);
        refresh_urgent_d = (pending_d >= URGENT_TH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            pending_q        <= '0;
            overflow_q       <= 1'b0;
            refresh_req_q    <= 1'b0;
            refresh_urgent_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            pending_q        <= pending_d;
            overflow_q       <= overflow_d;
            refresh_req_q    <= refresh_req_d;
            refresh_urgent_q <= refresh_urgent_d;
        end
    end

    assign refresh_req    = refresh_req_q;
    assign refresh_urgent = refresh_urgent_q;
    assign pending        = pending_q;
    assign overflow       = overflow_q;

    // The interval counter reloads at zero, so it can never exceed its reload value.
    a_cnt_in_range: assert property (@(posedge clk) disable iff (reset) cnt_count <= RELOAD);

endmodule

// File: tb/tb_sdram_refresh_timer.sv
// Directed vector table, hand-written latency sequences and a randomized run
// against a cycle-age reference model for sdram_refresh_timer.
module tb_sdram_refresh_timer;

    localparam int IV   = 10;
    localparam int MAXP = 8;
    localparam int URG  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       refresh_ack = 1'b0;
    logic       refresh_req;
    logic       refresh_urgent;
    logic [3:0] pending;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    sdram_refresh_timer #(
        .interval_cycles  (IV),
        .max_pending      (MAXP),
        .urgent_threshold (URG)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .refresh_ack    (refresh_ack),
        .refresh_req    (refresh_req),
        .refresh_urgent (refresh_urgent),
        .pending        (pending),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cycles;
        logic rst;
        logic en;
        logic ack;
        int   exp_pend;
        logic exp_ovf;
    } vec_t;

    vec_t vecs[$];

    // Reference model: tracks cycles spent in RUN; a tick falls on every
    // IV-th RUN cycle counted from entry.
    bit m_run  = 1'b0;
    int m_age  = 0;
    int m_pend = 0;
    bit m_ovf  = 1'b0;

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic a);
        reset       = r;
        enable      = e;
        refresh_ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic r, input logic e, input logic a);
        bit tk;
        if (r) begin
            m_run = 1'b0; m_pend = 0; m_ovf = 1'b0; m_age = 0;
        end else if (!e) begin
            m_run = 1'b0; m_pend = 0;
        end else if (!m_run) begin
            m_run = 1'b1; m_age = 0;
        end else begin
            tk = ((m_age % IV) == IV - 1);
            m_age++;
            if (tk && !a) begin
                if (m_pend == MAXP) m_ovf = 1'b1;
                else m_pend++;
            end else if (a && !tk && m_pend > 0) begin
                m_pend--;
            end
        end
    endtask

    task automatic check_outputs(input string tag, input int idx, input int p, input logic o);
        check({tag, "_pending"}, idx, int'(pending), p);
        check({tag, "_req"},     idx, int'(refresh_req), int'(p != 0));
        check({tag, "_urgent"},  idx, int'(refresh_urgent), int'(p >= URG));
        check({tag, "_overflow"},idx, int'(overflow), int'(o));
    endtask

    function automatic void add(input int c, input logic r, input logic e, input logic a,
                                input int p, input logic o);
        vec_t v;
        v.cycles = c; v.rst = r; v.en = e; v.ack = a; v.exp_pend = p; v.exp_ovf = o;
        vecs.push_back(v);
    endfunction

    task automatic wait_first_req(input string name, input int exp_edges);
        int n;
        n = 0;
        while (!refresh_req && n < 50) begin
            cycle(1'b0, 1'b1, 1'b0);
            n++;
        end
        check(name, 0, n, exp_edges);
    endtask

    initial begin
        int ack_mod;
        logic r, e, a;

        // Timeline comments give the visible cycle number after the row
        // (cycle 0 is the first RUN cycle).
        add(2,  1, 0, 0, 0, 0);
        add(10, 0, 1, 0, 0, 0);   // cycle 9: tick cycle, not yet visible
        add(1,  0, 1, 0, 1, 0);   // cycle 10
        add(9,  0, 1, 0, 1, 0);
        add(1,  0, 1, 0, 2, 0);   // 20
        add(10, 0, 1, 0, 3, 0);   // 30
        add(10, 0, 1, 0, 4, 0);   // 40: urgent
        add(1,  0, 1, 1, 3, 0);   // 41: ack drops urgent
        add(9,  0, 1, 0, 4, 0);   // 50
        add(1,  0, 1, 1, 3, 0);
        add(1,  0, 1, 1, 2, 0);   // 52
        add(7,  0, 1, 0, 2, 0);   // 59: counter at 0
        add(1,  0, 1, 1, 2, 0);   // tick + ack
        add(6,  0, 1, 0, 2, 0);   // 66: counter at 3
        add(1,  0, 0, 0, 0, 0);   // enable dropped
        add(1,  0, 1, 0, 0, 0);   // re-raised
        add(1,  0, 1, 1, 0, 0);   // ack at zero ignored
        add(8,  0, 1, 0, 0, 0);
        add(1,  0, 1, 0, 1, 0);   // 10 cycles after re-raise
        for (int p = 2; p <= MAXP; p++) add(10, 0, 1, 0, p, 0);
        add(10, 0, 1, 0, MAXP, 1);  // lost tick
        add(1,  0, 0, 0, 0, 1);
        add(1,  0, 1, 0, 0, 1);
        add(1,  1, 1, 1, 0, 0);   // reset wins over enable and ack
        add(11, 0, 1, 0, 1, 0);
        for (int p = 2; p <= MAXP; p++) add(10, 0, 1, 0, p, 0);
        add(9,  0, 1, 0, MAXP, 0);
        add(1,  0, 1, 1, MAXP, 0);  // tick + ack at max
        add(1,  1, 1, 0, 0, 0);   // reset mid-RUN

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].cycles; k++) cycle(vecs[i].rst, vecs[i].en, vecs[i].ack);
            check_outputs("vec", i, vecs[i].exp_pend, vecs[i].exp_ovf);
        end

        // First-tick latency measured in edges after the edge that samples enable.
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        wait_first_req("first_req_latency", 10);
        repeat (4) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("drop_pending", 0, int'(pending), 0);
        cycle(1'b0, 1'b1, 1'b0);
        wait_first_req("rearm_req_latency", 10);
        check("rearm_overflow", 0, int'(overflow), 0);

        // Randomized run against the model; ack density varies per epoch.
        cycle(1'b1, 1'b0, 1'b0);
        model_step(1'b1, 1'b0, 1'b0);
        ack_mod = 5;
        for (int t = 0; t < 4000; t++) begin
            if (t % 400 == 0) begin
                case ($urandom_range(0, 3))
                    0:       ack_mod = 0;
                    1:       ack_mod = 20;
                    2:       ack_mod = 5;
                    default: ack_mod = 2;
                endcase
            end
            r = ($urandom_range(0, 1499) == 0);
            e = ($urandom_range(0, 199) != 0);
            a = (ack_mod != 0) && ($urandom_range(0, ack_mod - 1) == 0);
            cycle(r, e, a);
            model_step(r, e, a);
            check_outputs("rand", t, m_pend, m_ovf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
